// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single-port data memory between the CPU (C) and a DMA/debug engine (D).
// CPU has default priority; a starvation counter and a bounded lock let D win.
module dm_port_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int BE_W         = 4,
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_wr,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [BE_W-1:0]   c_be,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [BE_W-1:0]   d_be,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_lock,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              dm_wr,
  output logic [BE_W-1:0]   dm_be,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_din,
  input  logic [DATA_W-1:0] dm_dout
);
  localparam logic [3:0] STARVE_TOP = 4'(STARVE_LIMIT);
  localparam logic [3:0] LOCK_TOP   = 4'(LOCK_MAX - 1);
  localparam logic       LOCK_ON    = (LOCK_MAX > 1);
  logic [3:0] r_starve_cnt, r_lock_cnt, w_starve_nxt, w_lock_cnt_nxt, w_lock_cnt_inc;
  logic       r_lock_own, w_lock_own_nxt, w_d_pri, w_c_rd, w_d_rd, w_lock_more;
  assign w_d_pri = r_lock_own || (r_starve_cnt == STARVE_TOP);
  // grants are forced low while reset is asserted
  assign d_gnt  = rst_n && d_req && (!c_req || w_d_pri);
  assign c_gnt  = rst_n && c_req && !d_gnt;
  assign w_c_rd = c_gnt && !c_wr;
  assign w_d_rd = d_gnt && !d_wr;
  always_comb begin
    dm_wr   = c_gnt ? c_wr    : d_gnt && d_wr;
    dm_be   = c_gnt ? c_be    : d_gnt ? d_be    : '0;
    dm_addr = c_gnt ? c_addr  : d_gnt ? d_addr  : '0;
    dm_din  = c_gnt ? c_wdata : d_gnt ? d_wdata : '0;
  end
  // an unlocked D grant with d_lock opens a burst; each locked grant counts toward LOCK_MAX
  assign w_lock_cnt_inc = r_lock_cnt + 4'd1;
  assign w_lock_more    = w_lock_cnt_inc != LOCK_TOP;
  always_comb begin
    w_starve_nxt   = (d_req && !d_gnt) ? ((r_starve_cnt == STARVE_TOP) ? r_starve_cnt : r_starve_cnt + 4'd1) : 4'd0;
    w_lock_own_nxt = (d_gnt && d_lock) ? (r_lock_own ? w_lock_more : LOCK_ON) : 1'b0;
    w_lock_cnt_nxt = (d_gnt && d_lock && r_lock_own && w_lock_more) ? w_lock_cnt_inc : 4'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_rvalid     <= 1'b0;
      d_rvalid     <= 1'b0;
      c_rdata      <= '0;
      d_rdata      <= '0;
      r_starve_cnt <= 4'd0;
      r_lock_cnt   <= 4'd0;
      r_lock_own   <= 1'b0;
    end else begin
      c_rvalid     <= w_c_rd;
      d_rvalid     <= w_d_rd;
      c_rdata      <= w_c_rd ? dm_dout : c_rdata;
      d_rdata      <= w_d_rd ? dm_dout : d_rdata;
      r_starve_cnt <= w_starve_nxt;
      r_lock_cnt   <= w_lock_cnt_nxt;
      r_lock_own   <= w_lock_own_nxt;
    end
  end
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: random and directed stimulus against a rule-level model, with a read-return scoreboard.
module tb_dm_port_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int LOCK_MAX     = 8;
  logic        clk = 0, rst_n;
  logic        c_req, c_wr, c_gnt, c_rvalid, d_req, d_wr, d_lock, d_gnt, d_rvalid, dm_wr;
  logic [9:0]  c_addr, d_addr, dm_addr;
  logic [3:0]  c_be, d_be, dm_be;
  logic [31:0] c_wdata, d_wdata, c_rdata, d_rdata, dm_din, dm_dout;
  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] cq [$];
  logic [31:0] dq [$];
  logic [31:0] d_hist = 0;
  logic        c_seen = 0, d_seen = 0;
  int          n_chk = 0, n_pass = 0;

  dm_port_arbiter #(.ADDR_W(10), .DATA_W(32), .BE_W(4), .STARVE_LIMIT(STARVE_LIMIT), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_be(c_be), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata), .d_lock(d_lock),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .dm_wr(dm_wr), .dm_be(dm_be), .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int a);
    return (a == 5) ? 32'hDEADBEEF : 32'(a) * 32'h9E3779B1 ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  assign dm_dout = mem[dm_addr];

  // memory model behind the arbiter
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (dm_wr) mem[dm_addr] <= merge(mem[dm_addr], dm_din, dm_be);
    end
  end

  // reference model: decides the winner from the arbitration rules, predicts memory traffic and pushes read expectations
  initial begin
    int  waits = 0, burst = 0;
    logic e_c, e_d, w;
    logic [9:0]  a;
    logic [3:0]  be;
    logic [31:0] din;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_c_gnt", c_gnt, 0);
        check("rst_d_gnt", d_gnt, 0);
        check("rst_c_rvalid", c_rvalid, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        check("rst_c_rdata", c_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_dm_wr", dm_wr, 0);
        cq.delete();
        dq.delete();
        waits = 0;
        burst = 0;
        c_seen = 0;
        d_seen = 0;
      end else begin
        e_d = d_req && (!c_req || waits >= STARVE_LIMIT || (burst > 0 && burst < LOCK_MAX));
        e_c = c_req && !e_d;
        w   = e_c ? c_wr : (e_d && d_wr);
        a   = e_c ? c_addr : e_d ? d_addr : 10'd0;
        be  = e_c ? c_be : e_d ? d_be : 4'd0;
        din = e_c ? c_wdata : e_d ? d_wdata : 32'd0;
        check("c_gnt", c_gnt, e_c);
        check("d_gnt", d_gnt, e_d);
        check("dm_wr", dm_wr, w);
        check("dm_addr", dm_addr, a);
        check("dm_be", dm_be, be);
        check("dm_din", dm_din, din);
        if (e_c || e_d) begin
          if (w) ref_mem[a] = merge(ref_mem[a], din, be);
          else if (e_c) cq.push_back(ref_mem[a]);
          else dq.push_back(ref_mem[a]);
        end
        waits = (d_req && !e_d) ? ((waits < STARVE_LIMIT) ? waits + 1 : waits) : 0;
        burst = (e_d && d_lock) ? ((burst == LOCK_MAX) ? 1 : burst + 1) : 0;
        d_hist = {d_hist[30:0], d_gnt};
        c_seen = c_gnt;
        d_seen = d_gnt;
      end
    end
  end

  // monitor: every cycle the rvalid flags must match the outstanding reads, and the data must match
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        check("c_rvalid", c_rvalid, cq.size() > 0);
        if (c_rvalid && cq.size() > 0) begin
          e = cq.pop_front();
          check("c_rdata", c_rdata, e);
        end else if (cq.size() > 0) void'(cq.pop_front());
        check("d_rvalid", d_rvalid, dq.size() > 0);
        if (d_rvalid && dq.size() > 0) begin
          e = dq.pop_front();
          check("d_rdata", d_rdata, e);
        end else if (dq.size() > 0) void'(dq.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    c_req = 0;
    d_req = 0;
    d_lock = 0;
  endtask

  initial begin
    logic [31:0] old;
    rst_n = 0;
    {c_req, c_wr, c_addr, c_be, c_wdata} = '0;
    {d_req, d_wr, d_addr, d_be, d_wdata, d_lock} = '0;
    cyc(3);
    rst_n = 1;
    c_req = 1; c_wr = 0; c_addr = 10'd5; c_be = 4'hF;
    cyc(1);
    c_req = 0;
    check("read5_c_rvalid", c_rvalid, 1);
    check("read5_c_rdata", c_rdata, 32'hDEADBEEF);
    check("read5_d_rvalid", d_rvalid, 0);
    cyc(1);
    c_req = 1; c_wr = 1; c_addr = 10'd9; c_be = 4'hF; c_wdata = 32'h11111111;
    d_req = 1; d_wr = 0; d_addr = 10'd7; d_be = 4'hF; d_lock = 0;
    cyc(6);
    check("starve_pattern", d_hist[5:0], 6'b000010);
    idle();
    cyc(1);
    d_req = 1; d_wr = 1; d_addr = 10'd3; d_be = 4'b0100; d_wdata = 32'h00AA0000;
    old = mem[3];
    cyc(1);
    d_req = 0;
    check("be_write_mem3", mem[3], (old & 32'hFF00FFFF) | 32'h00AA0000);
    check("be_write_no_rvalid", d_rvalid, 0);
    cyc(1);
    c_req = 1; c_wr = 1; c_addr = 10'd12; c_wdata = 32'h22222222;
    d_req = 1; d_wr = 0; d_addr = 10'd3; d_lock = 1;
    cyc(14);
    check("lock_pattern", d_hist[13:0], 14'b00001111111100);
    idle();
    cyc(1);
    c_req = 1; d_req = 1; d_lock = 1;
    cyc(6);
    d_lock = 0;
    cyc(3);
    check("unlock_pattern", d_hist[8:0], 9'b000011100);
    idle();
    cyc(1);
    for (int n = 0; n < 400; n++) begin
      if (!c_req || c_seen) begin
        c_req = $urandom_range(0, 3) != 0;
        c_wr = 1'($urandom);
        c_addr = 10'($urandom_range(0, 15));
        c_be = 4'($urandom);
        c_wdata = $urandom;
      end
      if (!d_req || d_seen) begin
        d_req = $urandom_range(0, 3) != 0;
        d_wr = 1'($urandom);
        d_addr = 10'($urandom_range(0, 15));
        d_be = 4'($urandom);
        d_wdata = $urandom;
        d_lock = $urandom_range(0, 3) != 0;
      end
      cyc(1);
    end
    idle();
    cyc(2);
    c_req = 1; c_wr = 0; c_addr = 10'd5; c_be = 4'hF;
    cyc(1);
    rst_n = 0;
    #1;
    check("midrst_c_rvalid", c_rvalid, 0);
    check("midrst_c_rdata", c_rdata, 0);
    check("midrst_c_gnt", c_gnt, 0);
    cyc(2);
    rst_n = 1;
    c_req = 0;
    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single-port data memory between two masters: the CPU MEM stage (port C) and a DMA/debug engine (port D).
- Each cycle it grants at most one master, drives the memory write strobe, byte enables, address and write data from the winner, and returns registered read data one cycle later.
- CPU has default priority. A starvation counter protects DMA; a bounded lock gives DMA atomic bursts. Sits between the pipeline/DMA and the memory plus its store byte-enable logic.

Parameters:
- ADDR_W, 10, word-address width into the data memory.
- DATA_W, 32, data width.
- BE_W, 4, byte-enable width (DATA_W/8).
- STARVE_LIMIT, 4, consecutive lost cycles before DMA is promoted above CPU (1..15).
- LOCK_MAX, 8, maximum consecutive locked DMA grants before the lock is forcibly broken for one cycle (1..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- c_req  in  1  CPU request.
- c_wr  in  1  CPU write (1) / read (0).
- c_addr  in  ADDR_W  CPU word address.
- c_be  in  BE_W  CPU byte enables.
- c_wdata  in  DATA_W  CPU write data.
- c_gnt  out  1  CPU granted this cycle (combinational).
- c_rvalid  out  1  CPU read data valid (registered).
- c_rdata  out  DATA_W  CPU read data (registered).
- d_req, d_wr, d_addr, d_be, d_wdata  in  1/1/ADDR_W/BE_W/DATA_W  DMA request fields, same meanings as the CPU fields.
- d_lock  in  1  DMA requests that it keep the grant next cycle.
- d_gnt  out  1  DMA granted this cycle.
- d_rvalid  out  1  DMA read data valid.
- d_rdata  out  DATA_W  DMA read data.
- dm_wr  out  1  memory write strobe.
- dm_be  out  BE_W  memory byte enables.
- dm_addr  out  ADDR_W  memory address.
- dm_din  out  DATA_W  memory write data.
- dm_dout  in  DATA_W  memory combinational read data.

Behaviour:
- Reset (rst_n=0, async):
  - c_rvalid=d_rvalid=0; c_rdata=d_rdata=0.
  - starve_cnt=0, lock_cnt=0, lock_own=0.
  - All outputs that depend on grants are 0 while both requests are low.
- Arbitration, combinational from req inputs and registered state:
  - Only one requester: it wins.
  - Both requesting, D wins if lock_own=1 or starve_cnt==STARVE_LIMIT. Otherwise C wins.
  - Exactly one of c_gnt/d_gnt is high when any req is high; neither when none.
- Memory drive:
  - Winner's wr/addr/be/wdata are muxed to dm_wr/dm_addr/dm_be/dm_din in the grant cycle.
  - No grant: dm_wr=0, dm_be=0, dm_addr=0, dm_din=0.
  - A write commits at the posedge ending the grant cycle. be=0 is a legal no-op write.
- Read return:
  - On a granted read (wr=0), dm_dout is captured into the winner's rdata at the posedge.
  - The winner's rvalid is high for exactly the next cycle. Latency is 1.
  - Writes never raise rvalid.
  - rdata holds its value until the next read for that port.
  - Back-to-back reads give back-to-back rvalid pulses.
- Requester rule:
  - A master holds req and its fields stable until it sees gnt high in the same cycle.
  - The request is consumed at that posedge.
- starve_cnt:
  - Incremented (saturating at STARVE_LIMIT) each cycle with d_req=1 and d_gnt=0.
  - Cleared on any cycle with d_gnt=1 or d_req=0.
- Lock:
  - lock_own is set at the posedge when d_gnt=1 and d_lock=1 and lock_cnt<LOCK_MAX-1.
  - lock_cnt increments on each locked grant.
  - When a locked grant makes lock_cnt reach LOCK_MAX-1, lock_own clears and lock_cnt resets to 0. The next cycle uses normal arbitration, so CPU wins if requesting.
  - lock_own clears immediately (same posedge) when d_req=0 or d_lock=0 on a D grant; lock_cnt resets to 0.
  - A lock never blocks the CPU for more than LOCK_MAX consecutive cycles.
- Simultaneous events: a starvation promotion and an active lock both favour D; no conflict.
- Reset mid-access: a pending rvalid is dropped, and a write whose posedge coincides with reset assertion is not guaranteed.

Test Plan:
- Reset, then C read addr 5 (mem[5]=0xDEADBEEF) with d_req=0 → c_gnt=1 same cycle; next cycle c_rvalid=1, c_rdata=0xDEADBEEF; d_rvalid=0.
- C and D both request continuously (C writes, D reads addr 7) with STARVE_LIMIT=4 → C granted 4 cycles, D granted in cycle 5, then C again; starve_cnt back to 0.
- D write addr 3, be=0b0100, wdata=0x00AA0000 alone → dm_wr=1, dm_be=0100; mem[3][23:16]=0xAA, other bytes unchanged; no rvalid.
- D holds d_req=d_lock=1 with LOCK_MAX=8 and c_req=1 → D granted 8 consecutive cycles, C granted on cycle 9.
- D drops d_lock during burst while C requests → C granted the very next cycle.
- Assert rst_n=0 the cycle after a granted read → c_rvalid=0, c_rdata=0 immediately; no grants while in reset.
